gate_exerciser: RTL
===================

# gate_exerciser

Synchronous, self-checking exerciser for any 2-input combinational gate in the logic-gate lab set (OR, AND, XOR, NAND, …). On a START request it drives all four input vectors onto the gate under test, waits a programmable settle time per vector, samples the gate output, and compares it with an expected truth table. It reports a pass/fail verdict, an error count and a per-vector failure mask. It is the on-chip checking end of the gate interface, replacing a manual stimulus-only fixture, and is used in FPGA bring-up of the gate modules.

## Interface
- TRUTH, 4'b1110: expected output per vector; bit index = {I1,I2}. Default is OR.
- SETTLE, 2: cycles each vector is held before sampling; legal range 1..15.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- START  in  1  run request; sampled only in IDLE.
- I1  out  1  gate-under-test input 1, registered.
- I2  out  1  gate-under-test input 2, registered.
- O  in  1  gate-under-test output.
- BUSY  out  1  high while a run is in progress.
- DONE  out  1  one-cycle pulse marking the end of a run.
- PASS  out  1  1 = the last completed run had zero mismatches.
- ERR_CNT  out  3  mismatch count of the last run, 0..4.
- ERR_VEC  out  4  mismatch mask of the last run; bit n = vector n failed.

## Operation
- States: IDLE, RUN, FIN.
- IDLE: I1=I2=0, BUSY=0. START=1 at a rising edge causes:
  - next state RUN;
  - vector index v=0, so {I1,I2}=2'b00;
  - settle counter cleared;
  - ERR_CNT, ERR_VEC and PASS cleared to 0;
  - BUSY=1.
- RUN: the settle counter increments each cycle. When it reaches SETTLE-1, the next edge is the sample edge for vector v:
  - O is compared with TRUTH[v];
  - on mismatch, ERR_VEC[v] is set and ERR_CNT increments;
  - if v<3: v increments, {I1,I2} takes the new v, and the counter clears;
  - if v=3: next state FIN, {I1,I2}=00, BUSY=0, DONE=1, and PASS = (no mismatch in this run, including vector 3).
- FIN: lasts one cycle. DONE drops and the block returns to IDLE unconditionally. START is ignored in FIN.
- START is ignored during RUN. A run cannot be aborted except by reset.
- ERR_CNT, ERR_VEC and PASS hold their values from the end of a run until the next accepted START.
- Vector order is fixed: 00, 01, 10, 11, with I1 as the MSB.
- ERR_CNT is 3 bits wide and saturates naturally at 4; no overflow is possible.

## Timing
- Reset values (RST_N low, asynchronous, all state): state=IDLE, I1=0, I2=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, ERR_VEC=0.
- RST_N deasserts synchronously to CLK at the block boundary; the first START is honoured at the first rising edge after release.
- Let edge E0 be the edge at which START is accepted. Vector n is driven from edge E0+n·SETTLE, and O is sampled at edge E0+(n+1)·SETTLE.
- DONE is high from edge E0+4·SETTLE for exactly one cycle. With SETTLE=2, DONE rises 8 cycles after acceptance.
- From DONE, the earliest next acceptance is 2 edges later: one edge for FIN→IDLE, then one edge in IDLE. START held high continuously therefore gives back-to-back runs with period 4·SETTLE+2.
- Reset asserted mid-run: outputs go to their reset values immediately, with no DONE pulse. Partial results are discarded.
- O must be stable at each sample edge; the gate's combinational delay must be shorter than SETTLE cycles.

## Test plan
- OR gate under test, TRUTH=1110, SETTLE=2, one START pulse -> {I1,I2} steps 00,01,10,11 at 2-cycle spacing; DONE at +8 cycles; PASS=1, ERR_CNT=0, ERR_VEC=0000.
- O tied to 0, default TRUTH -> PASS=0, ERR_CNT=3, ERR_VEC=1110, DONE at +8 cycles.
- AND gate under test with TRUTH=1110 -> ERR_VEC=0110, ERR_CNT=2, PASS=0. Rerun with TRUTH=1000 -> PASS=1, ERR_CNT=0.
- START pulsed again at +3 cycles during RUN -> ignored; DONE only once at +8 cycles. START held high with SETTLE=1 -> DONE pulses every 6 cycles.
- RST_N pulled low at +5 cycles of a run -> I1=I2=0, BUSY=0, and DONE, PASS, ERR_CNT, ERR_VEC all 0 within the same cycle. After release, a new START completes normally.
- SETTLE=15 with a correct XOR gate and TRUTH=0110 -> DONE at +60 cycles, PASS=1.

Source files
------------

// File: rtl/gate_exerciser.sv
// Self-checking exerciser for a 2-input combinational gate: steps {I1,I2}
// through 00,01,10,11, samples O after SETTLE cycles and scores it against TRUTH.
module gate_exerciser #(
  parameter logic [3:0]  TRUTH  = 4'b1110,
  parameter int unsigned SETTLE = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic       I1,
  output logic       I2,
  input  logic       O,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [2:0] ERR_CNT,
  output logic [3:0] ERR_VEC
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] vec;
  logic [3:0] cnt;
  logic       miss;
  logic [3:0] miss_mask;

  always_comb begin
    miss      = 1'b0;
    miss_mask = '0;
    if (O != TRUTH[vec]) begin
      miss           = 1'b1;
      miss_mask[vec] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      vec     <= '0;
      cnt     <= '0;
      I1      <= 1'b0;
      I2      <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      ERR_CNT <= '0;
      ERR_VEC <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            state   <= RUN;
            vec     <= '0;
            cnt     <= '0;
            {I1, I2} <= 2'b00;
            ERR_CNT <= '0;
            ERR_VEC <= '0;
            PASS    <= 1'b0;
            BUSY    <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            ERR_VEC <= ERR_VEC | miss_mask;
            ERR_CNT <= ERR_CNT + 3'(miss);
            if (vec != 2'd3) begin
              vec      <= vec + 2'd1;
              {I1, I2} <= vec + 2'd1;
              cnt      <= '0;
            end else begin
              state    <= FIN;
              {I1, I2} <= 2'b00;
              BUSY     <= 1'b0;
              DONE     <= 1'b1;
              // Verdict must include the vector being scored on this same edge.
              PASS     <= ((ERR_VEC | miss_mask) == 4'b0000);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FIN: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
